// File: rtl/move_pulse.sv
// -----------------------------------------------------------------------------
// move_pulse
//   Turns two raw push buttons (up / down) into clean one-cycle move pulses for
//   the row-position stage. Each button is synchronized (two flops), debounced
//   by a saturating-free level counter, and fed to a small IDLE/FIRE/HELD FSM
//   that issues a single pulse per accepted press. A pulse is dropped (never
//   deferred) when the other button is down or when game logic asserts hold.
//
//   First-pulse latency for a clean press is DEBOUNCE_CYCLES+3 rising edges,
//   counting the first edge that samples the button high.
//
//   Optional feature: define KEY_REPEAT_EN to compile in auto-repeat. A held
//   button then pulses again REPEAT_DELAY cycles after its first pulse and
//   every REPEAT_PERIOD cycles after that. Without the macro no repeat logic
//   exists.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronized samples to accept a level change
//                    (1..65535)
//   REPEAT_DELAY     first pulse to first auto-repeat pulse, in cycles
//   REPEAT_PERIOD    cycles between later auto-repeat pulses
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high reset
//   btnU   in   raw asynchronous up button, 1 = pressed
//   btnD   in   raw asynchronous down button, 1 = pressed
//   hold   in   freeze request from game logic, 1 = suppress all pulses
//   U      out  registered one-cycle up-move pulse
//   D      out  registered one-cycle down-move pulse
// -----------------------------------------------------------------------------
module move_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btnU,
    input  logic btnD,
    input  logic hold,
    output logic U,
    output logic D
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  db_q,    db_d;
    logic [15:0] cnt_q   [2];
    logic [15:0] cnt_d   [2];
    logic [16:0] cnt_inc [2];
    logic [1:0]  state_q [2];
    logic [1:0]  state_d [2];
    logic [1:0]  pulse_q, pulse_d;

`ifdef KEY_REPEAT_EN
    logic [15:0] rpt_cnt_q   [2];
    logic [15:0] rpt_cnt_d   [2];
    logic [16:0] rpt_cnt_inc [2];
    logic [1:0]  rpt_live_q,  rpt_live_d;   // repeat sequence still running
    logic [1:0]  rpt_first_q, rpt_first_d;  // next repeat uses REPEAT_DELAY
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            db_d[b]    = db_q[b];
            cnt_d[b]   = '0;
            cnt_inc[b] = {1'b0, cnt_q[b]} + 17'd1;
            state_d[b] = state_q[b];

            // Counter runs only while the synchronized level disagrees with
            // the debounced level; any agreement restarts it from zero.
            if (sync2_q[b] != db_q[b]) begin
                if (cnt_inc[b] == 17'(DEBOUNCE_CYCLES)) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_inc[b][15:0];
                end
            end

            case (state_q[b])
                ST_IDLE: if (db_q[b])  state_d[b] = ST_FIRE;
                ST_FIRE:               state_d[b] = ST_HELD;
                ST_HELD: if (!db_q[b]) state_d[b] = ST_IDLE;
                default:               state_d[b] = ST_IDLE;
            endcase

            // Pulse is registered on the same edge that enters FIRE, so it is
            // high exactly during the FIRE cycle. Suppression drops it.
            pulse_d[b] = (state_d[b] == ST_FIRE) && !db_q[b ^ 1] && !hold;

`ifdef KEY_REPEAT_EN
            rpt_cnt_d[b]   = rpt_cnt_q[b];
            rpt_cnt_inc[b] = {1'b0, rpt_cnt_q[b]} + 17'd1;
            rpt_live_d[b]  = rpt_live_q[b];
            rpt_first_d[b] = rpt_first_q[b];

            if (state_d[b] == ST_FIRE) begin
                // A suppressed first pulse means no repeats for this press.
                rpt_cnt_d[b]   = '0;
                rpt_first_d[b] = 1'b1;
                rpt_live_d[b]  = pulse_d[b];
            end else if (state_d[b] == ST_HELD && rpt_live_q[b]) begin
                if (db_q[b ^ 1] || hold) begin
                    rpt_live_d[b] = 1'b0;
                end else if (rpt_cnt_inc[b] == (rpt_first_q[b] ? 17'(REPEAT_DELAY)
                                                               : 17'(REPEAT_PERIOD))) begin
                    pulse_d[b]     = 1'b1;
                    rpt_cnt_d[b]   = '0;
                    rpt_first_d[b] = 1'b0;
                end else begin
                    rpt_cnt_d[b] = rpt_cnt_inc[b][15:0];
                end
            end else begin
                rpt_live_d[b] = 1'b0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            pulse_q <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b]   <= '0;
                state_q[b] <= ST_IDLE;
            end
`ifdef KEY_REPEAT_EN
            rpt_live_q  <= '0;
            rpt_first_q <= '0;
            for (int b = 0; b < 2; b++) rpt_cnt_q[b] <= '0;
`endif
        end else begin
            sync1_q <= {btnD, btnU};
            sync2_q <= sync1_q;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b]   <= cnt_d[b];
                state_q[b] <= state_d[b];
            end
`ifdef KEY_REPEAT_EN
            rpt_live_q  <= rpt_live_d;
            rpt_first_q <= rpt_first_d;
            for (int b = 0; b < 2; b++) rpt_cnt_q[b] <= rpt_cnt_d[b];
`endif
        end
    end

    assign U = pulse_q[0];
    assign D = pulse_q[1];

endmodule

// File: tb/tb_move_pulse.sv
// -----------------------------------------------------------------------------
// tb_move_pulse
//   Directed bench for move_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
//   REPEAT_PERIOD=4. Edge numbers count rising edges after the most recent
//   reset release; outputs are sampled 1 time unit after each edge. Expected
//   pulse positions are worked out by hand and depend on KEY_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_move_pulse;

    logic clk = 1'b0;
    logic reset, btnU, btnD, hold;
    logic U, D;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    bit exp_t1 [64];
    bit exp_t2 [64];

    always #5 clk = ~clk;

    move_pulse #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btnU (btnU),
        .btnD (btnD),
        .hold (hold),
        .U    (U),
        .D    (D)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b expected=%b", tag, edge_n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btnU  = 1'b0;
        btnD  = 1'b0;
        hold  = 1'b0;
        repeat (3) tick();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Hand-computed pulse edges: first pulse at edge 7 after a press
        // sampled from edge 1; repeats at +8 then every +4 while HELD.
`ifdef KEY_REPEAT_EN
        exp_t1[7] = 1; exp_t1[15] = 1; exp_t1[19] = 1; exp_t1[23] = 1;
        exp_t1[27] = 1; exp_t1[31] = 1; exp_t1[35] = 1;
        exp_t2[17] = 1; exp_t2[25] = 1;
`else
        exp_t1[7]  = 1;
        exp_t2[17] = 1;
`endif

        // Reset state: outputs low while reset is held.
        reset = 1'b1; btnU = 1'b1; btnD = 1'b1; hold = 1'b0;
        tick();
        repeat (3) begin
            tick();
            check("reset_U", U, 1'b0);
            check("reset_D", D, 1'b0);
        end

        // T1: btnU held for edges 1..30, then released; observe to edge 40.
        do_reset();
        btnU = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e == 31) btnU = 1'b0;
            tick();
            check("hold_up_U", U, exp_t1[e]);
            check("hold_up_D", D, 1'b0);
        end

        // T2: 2-cycle glitch on btnD, then a 10-cycle press from edge 11.
        do_reset();
        btnD = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3)  btnD = 1'b0;
            if (e == 11) btnD = 1'b1;
            if (e == 21) btnD = 1'b0;
            tick();
            check("glitch_press_D", D, exp_t2[e]);
            check("glitch_press_U", U, 1'b0);
        end

        // T3: both buttons rise together and are held, then released.
        do_reset();
        btnU = 1'b1;
        btnD = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            if (e == 21) begin btnU = 1'b0; btnD = 1'b0; end
            tick();
            check("both_U", U, 1'b0);
            check("both_D", D, 1'b0);
        end

        // T4: press held through hold, press+release inside hold, then a
        // fresh press with hold low pulses once at edge 56.
        do_reset();
        hold = 1'b1;
        btnU = 1'b1;
        for (int e = 1; e <= 63; e++) begin
            if (e == 11) hold = 1'b0;
            if (e == 21) begin btnU = 1'b0; hold = 1'b1; end
            if (e == 25) btnU = 1'b1;
            if (e == 33) btnU = 1'b0;
            if (e == 40) hold = 1'b0;
            if (e == 50) btnU = 1'b1;
            tick();
            check("hold_U", U, (e == 56));
            check("hold_D", D, 1'b0);
        end

        // T5: btnU held, reset asserted for the edge-10 sample only.
        do_reset();
        btnU = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            if (e == 10) reset = 1'b1;
            if (e == 11) reset = 1'b0;
            tick();
            check("midreset_U", U, (e == 7 || e == 17));
            check("midreset_D", D, 1'b0);
        end

        // T6: btnU held, btnD pressed from edge 8 -> D dropped, U repeats stop.
        do_reset();
        btnU = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 8) btnD = 1'b1;
            tick();
            check("cross_U", U, (e == 7));
            check("cross_D", D, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
